// File: rtl/adc_mem_capture.sv
// Single-shot dual-channel ADC capture into BRAM port B, optionally trigger-gated.
// Defining ADC_CAP_DECIM_EN adds cap_decim_i (write every (cap_decim_i+1)-th sample).
// state   | meaning
// IDLE    | waiting for an accepted start
// ARMED   | configuration latched, waiting for go (immediate) or trigger edge
// CAPTURE | registering ADC samples into memory
// DONE    | capture finished, done flag held until next start
module adc_mem_capture #(
  parameter int ADDR_WIDTH = 11,
  parameter int ADC_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_start_i,
  input  logic                  cap_abort_i,
  input  logic [ADDR_WIDTH-1:0] cap_len_i,
  input  logic                  trig_mode_i,
  input  logic                  trig_i,
  input  logic [ADC_WIDTH-1:0]  adc_ch0_i,
  input  logic [ADC_WIDTH-1:0]  adc_ch1_i,
`ifdef ADC_CAP_DECIM_EN
  input  logic [7:0]            cap_decim_i,
`endif
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_data_o,
  output logic                  cap_busy_o,
  output logic                  cap_done_o,
  output logic [ADDR_WIDTH:0]   cap_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_len_tgt, r_count;
  logic                  r_trig_mode, r_trig_d;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic                  w_accept, w_write, w_edge, w_dec_ok;
  logic [15:0]           w_ext0, w_ext1;

  assign w_ext0 = 16'($signed(adc_ch0_i));
  assign w_ext1 = 16'($signed(adc_ch1_i));
  assign w_edge = trig_i & ~r_trig_d;

`ifdef ADC_CAP_DECIM_EN
  logic [7:0] r_decim, r_dcnt;
  assign w_dec_ok = (r_dcnt == 8'd0);

  // Down-counter restarts at zero on entry so the first CAPTURE sample is always written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_decim <= 8'd0;
      r_dcnt  <= 8'd0;
    end else if (w_accept) begin
      r_decim <= cap_decim_i;
      r_dcnt  <= 8'd0;
    end else if (w_write) begin
      r_dcnt  <= r_decim;
    end else if (r_state == S_CAPTURE && r_dcnt != 8'd0) begin
      r_dcnt  <= r_dcnt - 8'd1;
    end
  end
`else
  assign w_dec_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (cap_start_i && !cap_abort_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (cap_abort_i)                     w_state_nxt = S_IDLE;
        else if (!r_trig_mode || w_edge)     w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cap_abort_i)                     w_state_nxt = S_IDLE;
        else if (r_count == r_len_tgt)       w_state_nxt = S_DONE;
        else                                 w_write     = w_dec_ok;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A zero length maps to 2^ADDR_WIDTH via the extra target bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len_tgt   <= '0;
      r_trig_mode <= 1'b0;
      r_trig_d    <= 1'b0;
      r_count     <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_trig_d <= trig_i;
      r_we     <= w_write;
      if (w_accept) begin
        r_len_tgt   <= {(cap_len_i == '0), cap_len_i};
        r_trig_mode <= trig_mode_i;
        r_count     <= '0;
      end else if (w_write) begin
        r_addr  <= r_count[ADDR_WIDTH-1:0];
        r_data  <= {w_ext1, w_ext0};
        r_count <= r_count + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  assign mem_addr_o  = r_addr;
  assign mem_we_o    = r_we;
  assign mem_data_o  = r_data;
  assign cap_busy_o  = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign cap_done_o  = (r_state == S_DONE);
  assign cap_count_o = r_count;

endmodule

// File: tb/tb_adc_mem_capture.sv
// Randomized bench for adc_mem_capture against a cycle-count model of the capture rules.
module tb_adc_mem_capture;
  localparam int AW  = 11;
  localparam int ADW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cap_start, cap_abort, cap_mode, trig;
  logic [AW-1:0] cap_len;
  logic [ADW-1:0] ch0, ch1;
  logic [AW-1:0] mem_addr;
  logic          mem_we, cap_busy, cap_done;
  logic [31:0]   mem_data;
  logic [AW:0]   cap_count;
`ifdef ADC_CAP_DECIM_EN
  logic [7:0]    cap_decim;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  bit            ramp_on = 1'b0;
  int            ramp_val = 0;
  logic [31:0]   cur_pack;

  adc_mem_capture #(.ADDR_WIDTH(AW), .ADC_WIDTH(ADW)) dut (
    .clk(clk), .rst_n(rst_n), .cap_start_i(cap_start), .cap_abort_i(cap_abort),
    .cap_len_i(cap_len), .trig_mode_i(cap_mode), .trig_i(trig),
    .adc_ch0_i(ch0), .adc_ch1_i(ch1),
`ifdef ADC_CAP_DECIM_EN
    .cap_decim_i(cap_decim),
`endif
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_data_o(mem_data),
    .cap_busy_o(cap_busy), .cap_done_o(cap_done), .cap_count_o(cap_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Two's-complement value of each channel, re-encoded as a 16-bit field.
  function automatic logic [31:0] pack(input logic [ADW-1:0] c0, input logic [ADW-1:0] c1);
    int v0, v1;
    v0 = (int'(c0) >= (1 << (ADW-1))) ? int'(c0) - (1 << ADW) : int'(c0);
    v1 = (int'(c1) >= (1 << (ADW-1))) ? int'(c1) - (1 << ADW) : int'(c1);
    return {v1[15:0], v0[15:0]};
  endfunction

  task automatic step();
    if (ramp_on) begin
      ch0 = ADW'(ramp_val);
      ch1 = 14'h3FFF;
      ramp_val++;
    end else begin
      ch0 = ADW'($urandom);
      ch1 = ADW'($urandom);
    end
    cur_pack = pack(ch0, ch1);
    @(posedge clk);
    #1;
  endtask

  task automatic status(input bit busy, input bit done, input int cnt);
    chk("busy",  64'(cap_busy),  64'(busy));
    chk("done",  64'(cap_done),  64'(done));
    chk("count", 64'(cap_count), 64'(cnt));
  endtask

  task automatic idle_steps(input int n, input bit done, input int cnt);
    repeat (n) begin
      step();
      chk("idle_we", 64'(mem_we), 64'(0));
      status(1'b0, done, cnt);
    end
  endtask

  task automatic capture(input int len_cfg, input bit mode, input int decim, input int hold,
                         input int abort_at, input bit poke, input int ramp_start);
    int  len_eff, w, s;
    bit  fin, exp_we;
    len_eff = (len_cfg == 0) ? (1 << AW) : len_cfg;
    if (mode) trig = 1'b1;
    cap_len   = AW'(len_cfg);
    cap_mode  = mode;
`ifdef ADC_CAP_DECIM_EN
    cap_decim = 8'(decim);
`endif
    cap_start = 1'b1;
    step();
    cap_start = 1'b0;
    cap_len   = AW'($urandom);
    cap_mode  = 1'($urandom);
`ifdef ADC_CAP_DECIM_EN
    cap_decim = 8'($urandom);
`endif
    chk("arm_we", 64'(mem_we), 64'(0));
    status(1'b1, 1'b0, 0);
    if (!mode) begin
      step();
      chk("go_we", 64'(mem_we), 64'(0));
      chk("go_busy", 64'(cap_busy), 64'(1));
    end else begin
      repeat (hold) begin
        step();
        chk("hold_we", 64'(mem_we), 64'(0));
        chk("hold_busy", 64'(cap_busy), 64'(1));
      end
      trig = 1'b0;
      step();
      chk("low_we", 64'(mem_we), 64'(0));
      trig = 1'b1;
      step();
      chk("edge_we", 64'(mem_we), 64'(0));
      chk("edge_busy", 64'(cap_busy), 64'(1));
    end
    if (ramp_start >= 0) begin
      ramp_on  = 1'b1;
      ramp_val = ramp_start;
    end
    w = 0; s = 0; fin = 1'b0;
    while (!fin) begin
      if (abort_at >= 0 && w == abort_at) begin
        cap_abort = 1'b1;
        cap_start = 1'($urandom);
        step();
        cap_abort = 1'b0;
        cap_start = 1'b0;
        chk("abort_we", 64'(mem_we), 64'(0));
        status(1'b0, 1'b0, w);
        fin = 1'b1;
      end else begin
        s++;
        if (poke && s == 2) begin
          cap_start = 1'b1;
          cap_len   = AW'($urandom);
        end
        step();
        cap_start = 1'b0;
        exp_we = (w < len_eff) && (((s - 1) % (decim + 1)) == 0);
        chk("we", 64'(mem_we), 64'(exp_we));
        if (exp_we) begin
          chk("addr", 64'(mem_addr), 64'(w % (1 << AW)));
          chk("data", 64'(mem_data), 64'(cur_pack));
          w++;
        end
        chk("count", 64'(cap_count), 64'(w));
        if (!exp_we && w == len_eff) begin
          chk("end_busy", 64'(cap_busy), 64'(0));
          chk("end_done", 64'(cap_done), 64'(1));
          fin = 1'b1;
        end else begin
          chk("run_busy", 64'(cap_busy), 64'(1));
          chk("run_done", 64'(cap_done), 64'(0));
        end
      end
    end
    ramp_on = 1'b0;
  endtask

  initial begin
    int len, ab, dec;
    rst_n = 1'b0; cap_start = 1'b0; cap_abort = 1'b0; cap_mode = 1'b0; trig = 1'b0;
    cap_len = '0; ch0 = '0; ch1 = '0;
`ifdef ADC_CAP_DECIM_EN
    cap_decim = 8'd0;
`endif
    step(); step();
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_we",   64'(mem_we),   64'(0));
    chk("rst_data", 64'(mem_data), 64'(0));
    status(1'b0, 1'b0, 0);
    rst_n = 1'b1;
    idle_steps(2, 1'b0, 0);

    // Abort alone, and start+abort together, are both no-ops in IDLE.
    cap_abort = 1'b1; cap_start = 1'b1; cap_len = AW'(5);
    step();
    cap_abort = 1'b0; cap_start = 1'b0;
    status(1'b0, 1'b0, 0);
    cap_abort = 1'b1;
    idle_steps(1, 1'b0, 0);
    cap_abort = 1'b0;

    capture(4, 1'b0, 0, 0, -1, 1'b0, 1);
    idle_steps(3, 1'b1, 4);
    capture(8, 1'b1, 0, 4, -1, 1'b0, -1);
    idle_steps(2, 1'b1, 8);
    capture(100, 1'b0, 0, 0, 10, 1'b0, -1);
    idle_steps(3, 1'b0, 10);
    capture(20, 1'b0, 0, 0, -1, 1'b1, -1);
    idle_steps(1, 1'b1, 20);

    cap_start = 1'b1; cap_abort = 1'b1; cap_len = AW'(3);
    step();
    cap_start = 1'b0; cap_abort = 1'b0;
    status(1'b0, 1'b1, 20);
    capture(2, 1'b0, 0, 0, -1, 1'b0, -1);
    idle_steps(2, 1'b1, 2);

    // Abort while ARMED waiting on a trigger.
    trig = 1'b1; cap_mode = 1'b1; cap_len = AW'(5); cap_start = 1'b1;
    step();
    cap_start = 1'b0;
    status(1'b1, 1'b0, 0);
    cap_abort = 1'b1;
    step();
    cap_abort = 1'b0;
    chk("armabort_we", 64'(mem_we), 64'(0));
    status(1'b0, 1'b0, 0);

`ifdef ADC_CAP_DECIM_EN
    capture(3, 1'b0, 2, 0, -1, 1'b0, 0);
    idle_steps(1, 1'b1, 3);
`endif

    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 40);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
`ifdef ADC_CAP_DECIM_EN
      dec = $urandom_range(0, 3);
`else
      dec = 0;
`endif
      capture(len, 1'($urandom), dec, $urandom_range(0, 3), ab, 1'($urandom), -1);
      idle_steps(1, (ab < 0), (ab < 0) ? len : ab);
    end

    capture(0, 1'b0, 0, 0, -1, 1'b0, -1);
    idle_steps(1, 1'b1, 1 << AW);

    // Reset in the middle of a full-length run.
    cap_mode = 1'b0; cap_len = '0; cap_start = 1'b1;
    step();
    cap_start = 1'b0;
    repeat (40) step();
    chk("pre_rst_we", 64'(mem_we), 64'(1));
    rst_n = 1'b0;
    step();
    chk("mrst_addr", 64'(mem_addr), 64'(0));
    chk("mrst_we",   64'(mem_we),   64'(0));
    chk("mrst_data", 64'(mem_data), 64'(0));
    status(1'b0, 1'b0, 0);
    rst_n = 1'b1;
    idle_steps(2, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
